paddle_key_conditioner: RTL and testbench

// - Turns raw DE2-115 push-button levels into the clean paddle controls used by the VGA generator (raket_up, raket_down).
// - Also produces a one-cycle serve strobe for the game logic.
// - Sits between the board KEY pins and the VGA generator, in the pixelClock domain.
// - Stages: 2-FF synchronise -> debounce -> resolve conflicting directions -> register outputs.

---
 rtl/paddle_key_conditioner_if.sv | 15 +
 rtl/paddle_key_conditioner.sv | 91 +++++++++
 tb/tb_paddle_key_conditioner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/paddle_key_conditioner_if.sv
// Raw DE2-115 keys in, conditioned paddle levels and serve strobe out.
interface paddle_key_conditioner_if;
  logic       keyUpRaw;
  logic       keyDownRaw;
  logic       keyServeRaw;
  logic       raket_up;
  logic       raket_down;
  logic       servePulse;
  logic [2:0] keyState;

  modport master (output keyUpRaw, keyDownRaw, keyServeRaw,
                  input  raket_up, raket_down, servePulse, keyState);
  modport slave  (input  keyUpRaw, keyDownRaw, keyServeRaw,
                  output raket_up, raket_down, servePulse, keyState);
endinterface

// File: rtl/paddle_key_conditioner.sv
// Push-button conditioner: 2-FF sync, per-key debounce, direction conflict
// resolution and a one-shot serve strobe, all in the pixelClock domain.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 325000,
  parameter int CNT_W           = 19
) (
  input  logic pixelClock,
  input  logic reset,
  input  logic pressed,
  output logic db
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any sample agreeing with db restarts the run; db moves only after a full run.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (pressed == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= pressed;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module paddle_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 325000,
  parameter int CNT_W           = 19,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input logic                      pixelClock,
  input logic                      reset,
  paddle_key_conditioner_if.slave  keys
);
  localparam int NUM_LANES = 3;
  localparam int STAGES    = 1;

  logic [NUM_LANES-1:0]      raw, pressed, db;
  logic [1:0][NUM_LANES-1:0] sync;
  logic [STAGES:0]           vld_pipe;
  logic                      serve_armed, db_serve_d;
  logic                      raket_up_q, raket_down_q, serve_pulse_q;

  assign raw     = {keys.keyServeRaw, keys.keyDownRaw, keys.keyUpRaw};
  assign pressed = sync[1] ^ {NUM_LANES{KEY_ACTIVE_LOW}};

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_lane [NUM_LANES-1:0] (
    .pixelClock (pixelClock),
    .reset      (reset),
    .pressed    (pressed),
    .db         (db)
  );

  // vld_pipe marks when sync[1] carries a real post-reset key sample, so a
  // serve key held through reset cannot arm from the reset-loaded level.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      sync          <= {2*NUM_LANES{KEY_ACTIVE_LOW}};
      vld_pipe      <= '0;
      serve_armed   <= 1'b0;
      db_serve_d    <= 1'b0;
      raket_up_q    <= 1'b0;
      raket_down_q  <= 1'b0;
      serve_pulse_q <= 1'b0;
    end else begin
      sync          <= {sync[0], raw};
      vld_pipe      <= {vld_pipe[STAGES-1:0], 1'b1};
      if (vld_pipe[STAGES] && !pressed[2] && !db[2])
        serve_armed <= 1'b1;
      db_serve_d    <= db[2];
      raket_up_q    <= db[0] & ~db[1];
      raket_down_q  <= db[1] & ~db[0];
      serve_pulse_q <= serve_armed & db[2] & ~db_serve_d;
    end
  end

  assign keys.raket_up   = raket_up_q;
  assign keys.raket_down = raket_down_q;
  assign keys.servePulse = serve_pulse_q;
  assign keys.keyState   = db;
endmodule

// File: tb/tb_paddle_key_conditioner.sv
// Table-driven and randomized checks of paddle_key_conditioner against a sample-history model.
module tb_paddle_key_conditioner;
  localparam int D = 4;

  logic pixelClock = 1'b0;
  logic reset      = 1'b1;
  always #5 pixelClock = ~pixelClock;

  paddle_key_conditioner_if kif();

  paddle_key_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .pixelClock (pixelClock),
    .reset      (reset),
    .keys       (kif.slave)
  );

  typedef struct {
    logic [2:0] press;   // {serve,down,up}, 1 = pressed
    int         hold;
    logic       up;
    logic       down;
    logic [2:0] ks;
  } vec_t;

  int n_vec = 0, n_bad = 0, pulse_cnt = 0;

  // Reference model: raw pressed samples per edge, prefixed by the two reset-loaded sync levels.
  logic [2:0] raw_q[$];
  logic [2:0] seen_q[$];
  logic [2:0] m_db, m_db_prev;
  logic       m_armed, m_up, m_down, m_pulse;
  int         m_edges;

  task automatic model_reset();
    raw_q = '{3'b000, 3'b000};
    seen_q.delete();
    m_db = 3'b000; m_db_prev = 3'b000;
    m_armed = 1'b0; m_up = 1'b0; m_down = 1'b0; m_pulse = 1'b0;
    m_edges = 0;
  endtask

  task automatic model_edge(input logic [2:0] p);
    logic [2:0] seen, db_old;
    bit all_diff;
    seen = raw_q[raw_q.size()-2];
    raw_q.push_back(p);
    seen_q.push_back(seen);
    while (raw_q.size() > 4) void'(raw_q.pop_front());
    while (seen_q.size() > D) void'(seen_q.pop_front());
    db_old  = m_db;
    m_up    = db_old[0] & ~db_old[1];
    m_down  = db_old[1] & ~db_old[0];
    m_pulse = m_armed & db_old[2] & ~m_db_prev[2];
    if (m_edges >= 2 && !seen[2] && !db_old[2]) m_armed = 1'b1;
    // A level is accepted once the last D synchronised samples all disagree with it.
    for (int k = 0; k < 3; k++) begin
      if (seen_q.size() == D) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (seen_q[j][k] == db_old[k]) all_diff = 1'b0;
        if (all_diff) m_db[k] = ~db_old[k];
      end
    end
    m_db_prev = db_old;
    m_edges++;
  endtask

  task automatic check(input string name);
    n_vec++;
    if ({kif.raket_up, kif.raket_down, kif.servePulse, kif.keyState} !==
        {m_up, m_down, m_pulse, m_db}) begin
      n_bad++;
      $display("FAIL %s t=%0t: got up/dn/pulse/ks=%b%b%b/%b required %b%b%b/%b", name, $time,
               kif.raket_up, kif.raket_down, kif.servePulse, kif.keyState,
               m_up, m_down, m_pulse, m_db);
    end
    if (kif.servePulse === 1'b1) pulse_cnt++;
  endtask

  task automatic expect_val(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] p);
    {kif.keyServeRaw, kif.keyDownRaw, kif.keyUpRaw} = ~p;
  endtask

  task automatic step(input logic [2:0] p, input string name);
    drive(p);
    @(posedge pixelClock);
    model_edge(p);
    #1 check(name);
  endtask

  task automatic apply_reset(input logic [2:0] p);
    drive(p);
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_async");
    expect_val("reset_outputs_zero",
               int'({kif.raket_up, kif.raket_down, kif.servePulse, kif.keyState}), 0);
    repeat (3) @(posedge pixelClock);
    #1 check("reset_hold");
    reset = 1'b0;
  endtask

  vec_t tbl[15];
  int   first_idx;

  initial begin
    tbl[0]  = '{3'b001,  6, 1'b0, 1'b0, 3'b001};
    tbl[1]  = '{3'b001,  1, 1'b1, 1'b0, 3'b001};
    tbl[2]  = '{3'b001, 13, 1'b1, 1'b0, 3'b001};
    tbl[3]  = '{3'b000,  6, 1'b1, 1'b0, 3'b000};
    tbl[4]  = '{3'b000,  1, 1'b0, 1'b0, 3'b000};
    tbl[5]  = '{3'b010,  3, 1'b0, 1'b0, 3'b000};
    tbl[6]  = '{3'b000, 10, 1'b0, 1'b0, 3'b000};
    tbl[7]  = '{3'b010,  4, 1'b0, 1'b0, 3'b000};
    tbl[8]  = '{3'b000,  2, 1'b0, 1'b0, 3'b010};
    tbl[9]  = '{3'b000, 10, 1'b0, 1'b0, 3'b000};
    tbl[10] = '{3'b001, 20, 1'b1, 1'b0, 3'b001};
    tbl[11] = '{3'b011, 20, 1'b0, 1'b0, 3'b011};
    tbl[12] = '{3'b010,  6, 1'b0, 1'b0, 3'b010};
    tbl[13] = '{3'b010,  1, 1'b0, 1'b1, 3'b010};
    tbl[14] = '{3'b000, 10, 1'b0, 1'b0, 3'b000};

    apply_reset(3'b000);

    // Up/down latency, glitch rejection and conflict resolution.
    for (int i = 0; i < 15; i++) begin
      for (int c = 0; c < tbl[i].hold; c++) step(tbl[i].press, "table_cycle");
      expect_val($sformatf("table[%0d].raket_up", i), int'(kif.raket_up), int'(tbl[i].up));
      expect_val($sformatf("table[%0d].raket_down", i), int'(kif.raket_down), int'(tbl[i].down));
      expect_val($sformatf("table[%0d].keyState", i), int'(kif.keyState), int'(tbl[i].ks));
    end
    expect_val("table_no_serve_pulse", pulse_cnt, 0);

    // Serve held 50 cycles after a release: one pulse, 7 edges after the press.
    pulse_cnt = 0; first_idx = -1;
    for (int c = 0; c < 50; c++) begin
      step(3'b100, "serve_hold");
      if (kif.servePulse === 1'b1 && first_idx < 0) first_idx = c;
    end
    expect_val("serve_pulse_count", pulse_cnt, 1);
    expect_val("serve_pulse_edge", first_idx, 6);
    for (int c = 0; c < 10; c++) step(3'b000, "serve_release");

    // Serve held across reset deassertion: no pulse until released and pressed again.
    apply_reset(3'b100);
    pulse_cnt = 0;
    for (int c = 0; c < 30; c++) step(3'b100, "serve_through_reset");
    expect_val("serve_held_through_reset_no_pulse", pulse_cnt, 0);
    for (int c = 0; c < 10; c++) step(3'b000, "serve_release2");
    for (int c = 0; c < 20; c++) step(3'b100, "serve_repress");
    expect_val("serve_repress_pulse_count", pulse_cnt, 1);
    for (int c = 0; c < 10; c++) step(3'b000, "serve_release3");

    // Reset mid-debounce clears outputs at once and discards the partial count.
    for (int c = 0; c < 20; c++) step(3'b001, "pre_reset_up");
    expect_val("pre_reset_raket_up", int'(kif.raket_up), 1);
    for (int c = 0; c < 4; c++) step(3'b011, "down_partial");
    apply_reset(3'b000);
    for (int c = 0; c < 5; c++) step(3'b010, "fresh_down");
    expect_val("fresh_press_not_yet", int'(kif.keyState), 0);
    step(3'b010, "fresh_down");
    expect_val("fresh_press_accepted", int'(kif.keyState), 2);
    for (int c = 0; c < 10; c++) step(3'b000, "fresh_release");

    // Randomized key patterns with occasional resets.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] p;
      int hold;
      p    = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) apply_reset(p);
      for (int c = 0; c < hold; c++) step(p, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
